// File: rtl/wb_register_file.sv
// Writeback stage: selects the writeback value, resolves the destination (JAL link override),
// commits into a 32x32 register file with same-cycle read bypass, and keeps a writeback trace.
module wb_register_file #(
  parameter int LINK_REG       = 31,
  parameter bit ALLOW_R0_WRITE = 1'b0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        inRegWrite,
  input  logic        inJalSel,
  input  logic [1:0]  inMemToReg,
  input  logic [4:0]  inWriteReg,
  input  logic [31:0] inALUResult,
  input  logic [31:0] inMemData,
  input  logic [31:0] inLinkAddr,
  input  logic [4:0]  inReadReg1,
  input  logic [4:0]  inReadReg2,
  output logic [31:0] outReadData1,
  output logic [31:0] outReadData2,
  output logic        outWBValid,
  output logic [4:0]  outWBReg,
  output logic [31:0] outWBData
);

  localparam logic [4:0] LINK_IDX = 5'(LINK_REG);

  logic [31:0] regs_r [32];
  logic [31:0] wdata_s;
  logic [4:0]  dest_s;
  logic        commit_s;
  logic        bypass_s;
  logic [31:0] rd1_s;
  logic [31:0] rd2_s;
  logic        wb_valid_r;
  logic [4:0]  wb_reg_r;
  logic [31:0] wb_data_r;

  // Writeback source select; encoding 2'b11 aliases the ALU result so nothing goes unknown
  always_comb begin
    wdata_s = inALUResult;
    case (inMemToReg)
      2'b01:   wdata_s = inMemData;
      2'b10:   wdata_s = inLinkAddr;
      default: wdata_s = inALUResult;
    endcase
  end

  // Destination resolution and commit qualification
  always_comb begin
    dest_s = inWriteReg;
    if (inJalSel) begin
      dest_s = LINK_IDX;
    end else begin
      dest_s = inWriteReg;
    end
    commit_s = inRegWrite && ((dest_s != 5'd0) || ALLOW_R0_WRITE);
    // Bypass is held off during reset so the ports read the cleared array
    bypass_s = commit_s && Reset;
  end

  // Read port 1 with same-cycle write bypass
  always_comb begin
    rd1_s = regs_r[inReadReg1];
    if ((inReadReg1 == 5'd0) && !ALLOW_R0_WRITE) begin
      rd1_s = 32'd0;
    end else if (bypass_s && (inReadReg1 == dest_s)) begin
      rd1_s = wdata_s;
    end else begin
      rd1_s = regs_r[inReadReg1];
    end
  end

  // Read port 2 with same-cycle write bypass
  always_comb begin
    rd2_s = regs_r[inReadReg2];
    if ((inReadReg2 == 5'd0) && !ALLOW_R0_WRITE) begin
      rd2_s = 32'd0;
    end else if (bypass_s && (inReadReg2 == dest_s)) begin
      rd2_s = wdata_s;
    end else begin
      rd2_s = regs_r[inReadReg2];
    end
  end

  assign outReadData1 = rd1_s;
  assign outReadData2 = rd2_s;

  // Architectural register array commit
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (commit_s) begin
      regs_r[dest_s] <= wdata_s;
    end
  end

  // Writeback trace: valid every edge, register/data held when nothing commits
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wb_valid_r <= 1'b0;
      wb_reg_r   <= 5'd0;
      wb_data_r  <= 32'd0;
    end else begin
      wb_valid_r <= commit_s;
      if (commit_s) begin
        wb_reg_r  <= dest_s;
        wb_data_r <= wdata_s;
      end
    end
  end

  assign outWBValid = wb_valid_r;
  assign outWBReg   = wb_reg_r;
  assign outWBData  = wb_data_r;

endmodule

// File: tb/tb_wb_register_file.sv
// Directed bench for wb_register_file: a scoreboard queue holds the expected writeback trace
// per edge, a negedge monitor pops and compares; read ports are checked directly.
module tb_wb_register_file;

  logic        Clk;
  logic        Reset;
  logic        inRegWrite;
  logic        inJalSel;
  logic [1:0]  inMemToReg;
  logic [4:0]  inWriteReg;
  logic [31:0] inALUResult;
  logic [31:0] inMemData;
  logic [31:0] inLinkAddr;
  logic [4:0]  inReadReg1;
  logic [4:0]  inReadReg2;
  logic [31:0] outReadData1;
  logic [31:0] outReadData2;
  logic        outWBValid;
  logic [4:0]  outWBReg;
  logic [31:0] outWBData;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rg;
    logic [31:0] data;
  } trace_t;

  trace_t sb[$];
  int total = 0;
  int bad   = 0;

  wb_register_file dut (
    .Clk(Clk), .Reset(Reset), .inRegWrite(inRegWrite), .inJalSel(inJalSel),
    .inMemToReg(inMemToReg), .inWriteReg(inWriteReg), .inALUResult(inALUResult),
    .inMemData(inMemData), .inLinkAddr(inLinkAddr), .inReadReg1(inReadReg1),
    .inReadReg2(inReadReg2), .outReadData1(outReadData1), .outReadData2(outReadData2),
    .outWBValid(outWBValid), .outWBReg(outWBReg), .outWBData(outWBData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: the DUT presents a new trace after every edge; compare at the following negedge
  always @(negedge Clk) begin
    trace_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("wb_valid", {31'd0, outWBValid}, {31'd0, e.valid});
      chk("wb_reg",   {27'd0, outWBReg},   {27'd0, e.rg});
      chk("wb_data",  outWBData,           e.data);
    end
  end

  task automatic tick(input logic v, input logic [4:0] r, input logic [31:0] d);
    trace_t e;
    @(posedge Clk);
    e.valid = v; e.rg = r; e.data = d;
    sb.push_back(e);
    @(negedge Clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic jal, input logic [1:0] src,
                       input logic [4:0] wr, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] lnk);
    inRegWrite = we; inJalSel = jal; inMemToReg = src; inWriteReg = wr;
    inALUResult = alu; inMemData = mem; inLinkAddr = lnk;
  endtask

  task automatic rd(input string name, input logic [4:0] a, input logic [4:0] b,
                    input logic [31:0] ea, input logic [31:0] eb);
    inReadReg1 = a; inReadReg2 = b;
    #1;
    chk({name, "_p1"}, outReadData1, ea);
    chk({name, "_p2"}, outReadData2, eb);
  endtask

  initial begin
    Reset = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0);
    inReadReg1 = 5'd5; inReadReg2 = 5'd31;
    #12;
    rd("reset_rd", 5'd5, 5'd31, 32'd0, 32'd0);
    chk("reset_trace", {outWBValid, outWBReg, outWBData}, 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    #1;

    // Preload r5, then reset mid-cycle during a pending write to r6
    drive(1'b1, 1'b0, 2'b00, 5'd5, 32'h0000_1234, 32'd0, 32'd0);
    tick(1'b1, 5'd5, 32'h0000_1234);
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0);
    rd("preload", 5'd5, 5'd5, 32'h0000_1234, 32'h0000_1234);
    drive(1'b1, 1'b0, 2'b00, 5'd6, 32'h0000_0099, 32'd0, 32'd0);
    rd("pre_rst_bypass", 5'd6, 5'd5, 32'h0000_0099, 32'h0000_1234);
    Reset = 1'b0;
    rd("mid_rst", 5'd5, 5'd6, 32'd0, 32'd0);
    chk("mid_rst_valid", {31'd0, outWBValid}, 32'd0);
    chk("mid_rst_reg",   {27'd0, outWBReg},   32'd0);
    chk("mid_rst_data",  outWBData,           32'd0);
    @(posedge Clk);
    @(negedge Clk);
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0);
    Reset = 1'b1;
    #1;
    tick(1'b0, 5'd0, 32'd0);
    rd("post_rst", 5'd5, 5'd6, 32'd0, 32'd0);

    // ALU then load writeback
    drive(1'b1, 1'b0, 2'b00, 5'd8, 32'hDEAD_BEEF, 32'h1111_1111, 32'd0);
    tick(1'b1, 5'd8, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 2'b01, 5'd9, 32'h1111_1111, 32'hCAFE_F00D, 32'd0);
    tick(1'b1, 5'd9, 32'hCAFE_F00D);
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0);
    rd("alu_load", 5'd8, 5'd9, 32'hDEAD_BEEF, 32'hCAFE_F00D);

    // JAL link override
    drive(1'b1, 1'b1, 2'b10, 5'd4, 32'h5555_5555, 32'h6666_6666, 32'h0000_0048);
    tick(1'b1, 5'd31, 32'h0000_0048);
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0);
    rd("jal", 5'd31, 5'd4, 32'h0000_0048, 32'd0);

    // r0 write is dropped; trace holds the JAL entry
    drive(1'b1, 1'b0, 2'b00, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'd0);
    rd("r0_bypass", 5'd0, 5'd0, 32'd0, 32'd0);
    tick(1'b0, 5'd31, 32'h0000_0048);
    rd("r0_after", 5'd0, 5'd31, 32'd0, 32'h0000_0048);

    // Bypass: r10=0x11 then same-cycle overwrite with 0x22
    drive(1'b1, 1'b0, 2'b00, 5'd10, 32'h0000_0011, 32'd0, 32'd0);
    tick(1'b1, 5'd10, 32'h0000_0011);
    drive(1'b0, 1'b0, 2'b00, 5'd10, 32'h0000_0022, 32'd0, 32'd0);
    rd("byp_off", 5'd10, 5'd10, 32'h0000_0011, 32'h0000_0011);
    inRegWrite = 1'b1;
    rd("byp_pre", 5'd10, 5'd10, 32'h0000_0022, 32'h0000_0022);
    tick(1'b1, 5'd10, 32'h0000_0022);
    rd("byp_post_we", 5'd10, 5'd10, 32'h0000_0022, 32'h0000_0022);
    inRegWrite = 1'b0;
    rd("byp_post", 5'd10, 5'd10, 32'h0000_0022, 32'h0000_0022);

    // Source 11 aliases ALU; then a disabled write leaves r3 alone
    drive(1'b1, 1'b0, 2'b11, 5'd3, 32'h0000_0077, 32'h0000_0088, 32'h0000_0099);
    tick(1'b1, 5'd3, 32'h0000_0077);
    drive(1'b0, 1'b0, 2'b00, 5'd3, 32'h0000_0123, 32'h0000_0456, 32'd0);
    tick(1'b0, 5'd3, 32'h0000_0077);
    rd("src11_dis", 5'd3, 5'd8, 32'h0000_0077, 32'hDEAD_BEEF);

    // Back-to-back writes: last edge wins
    drive(1'b1, 1'b0, 2'b00, 5'd12, 32'h0000_000A, 32'd0, 32'd0);
    tick(1'b1, 5'd12, 32'h0000_000A);
    rd("b2b_mid", 5'd12, 5'd10, 32'h0000_000A, 32'h0000_0022);
    drive(1'b1, 1'b0, 2'b01, 5'd12, 32'd0, 32'h0000_000B, 32'd0);
    tick(1'b1, 5'd12, 32'h0000_000B);
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0);
    rd("b2b", 5'd12, 5'd9, 32'h0000_000B, 32'hCAFE_F00D);

    @(negedge Clk);
    #1;
    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
